// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - RV32I multi-cycle program-counter sequencer
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic        stall,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic [1:0]  next_pc_sel,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        commit,
    output logic        trap,
    output logic        halted,
    output logic [31:0] instret
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_TRAP  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic        cond_true;
    logic        misaligned;
    logic [31:0] jalr_target;

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            3'b000:  cond_true = (rs1_data == rs2_data);
            3'b001:  cond_true = (rs1_data != rs2_data);
            3'b100:  cond_true = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond_true = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond_true = (rs1_data <  rs2_data);
            3'b111:  cond_true = (rs1_data >= rs2_data);
            default: cond_true = 1'b0;
        endcase
    end

    assign pc_plus_4   = pc_q + 32'd4;
    assign jalr_target = (rs1_data + imm) & ~32'd1;

    always_comb begin
        next_pc_sel = 2'b00;
        if (state_q == S_EXEC) begin
            if (is_jalr)
                next_pc_sel = 2'b10;
            else if (is_jal || (is_branch && cond_true))
                next_pc_sel = 2'b01;
        end
    end

    always_comb begin
        next_pc = pc_plus_4;
        case (next_pc_sel)
            2'b01:   next_pc = pc_q + imm;
            2'b10:   next_pc = jalr_target;
            default: next_pc = pc_plus_4;
        endcase
    end

    assign taken      = (next_pc_sel != 2'b00);
    assign misaligned = taken && (next_pc[1:0] != 2'b00);

    // halt_req outranks stall and any retirement in EXEC
    assign commit = (state_q == S_EXEC) && !halt_req && !stall && !misaligned;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (halt_req)
                    state_d = S_HALT;
                else if (imem_gnt)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (halt_req)
                    state_d = S_HALT;
                else if (!stall) begin
                    if (misaligned)
                        state_d = S_TRAP;
                    else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign trap      = (state_q == S_TRAP);
    assign halted    = (state_q == S_HALT);
    assign instret   = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt;
    logic [31:0] imem_addr;
    logic        is_branch, is_jal, is_jalr, stall, halt_req;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [31:0] pc, pc_plus_4, next_pc, instret;
    logic [1:0]  next_pc_sel;
    logic        taken, commit, trap, halted;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_pc, m_instret;

    pc_sequencer #(.RESET_PC(32'h0), .TRAP_VECTOR(TRAP_VEC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .stall(stall), .halt_req(halt_req),
        .pc(pc), .pc_plus_4(pc_plus_4), .next_pc_sel(next_pc_sel),
        .next_pc(next_pc), .taken(taken), .commit(commit), .trap(trap),
        .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_dec();
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; funct3 = 3'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; stall = 1'b0;
    endtask

    // Architectural reference: branch rule table and target arithmetic
    function automatic void ref_exec(input logic br, input logic jal, input logic jalr,
                                     input logic [2:0] f3, input logic [31:0] cur_pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] im,
                                     output logic [1:0] sel, output logic [31:0] tgt);
        bit c;
        case (f3)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = ($signed(a) >= $signed(b));
            3'd6: c = (a < b);
            3'd7: c = (a >= b);
            default: c = 1'b0;
        endcase
        if (jalr) begin
            sel = 2'b10; tgt = (a + im) & 32'hFFFF_FFFE;
        end else if (jal || (br && c)) begin
            sel = 2'b01; tgt = cur_pc + im;
        end else begin
            sel = 2'b00; tgt = cur_pc + 32'd4;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; halt_req = 1'b0; clear_dec();
        cyc(); cyc();
        check32("rst_pc", pc, 32'h0);
        check32("rst_instret", instret, 32'h0);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check1("rst_trap", trap, 1'b0);
        check1("rst_commit", commit, 1'b0);
        check32("rst_sel", {30'd0, next_pc_sel}, 32'd0);
        rst_n = 1'b1;
        m_pc = 32'h0; m_instret = 32'h0;
    endtask

    task automatic do_fetch(input int delay);
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin cyc(); n++; end
        check1("fetch_req", imem_req, 1'b1);
        check32("fetch_addr", imem_addr, m_pc);
        repeat (delay) begin
            cyc();
            check1("fetch_hold", imem_req, 1'b1);
        end
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
    endtask

    task automatic do_exec(input logic br, input logic jal, input logic jalr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] im, input int stalls);
        logic [1:0]  es;
        logic [31:0] et;
        logic        mis;
        is_branch = br; is_jal = jal; is_jalr = jalr; funct3 = f3;
        rs1_data = a; rs2_data = b; imm = im;
        ref_exec(br, jal, jalr, f3, m_pc, a, b, im, es, et);
        mis = (es != 2'b00) && (et[1:0] != 2'b00);
        stall = 1'b1;
        repeat (stalls) begin
            #1;
            check1("stall_commit", commit, 1'b0);
            cyc();
            check32("stall_pc", pc, m_pc);
            check32("stall_instret", instret, m_instret);
        end
        stall = 1'b0;
        #1;
        check32("sel", {30'd0, next_pc_sel}, {30'd0, es});
        check32("next_pc", next_pc, et);
        check1("taken", taken, es != 2'b00);
        check1("commit", commit, !mis);
        check32("pc_plus_4", pc_plus_4, m_pc + 32'd4);
        cyc();
        clear_dec();
        if (mis) begin
            check1("trap_pulse", trap, 1'b1);
            check1("trap_commit", commit, 1'b0);
            check32("trap_pc_hold", pc, m_pc);
            cyc();
            check1("trap_end", trap, 1'b0);
            m_pc = TRAP_VEC;
        end else begin
            m_pc = et;
            m_instret = m_instret + 32'd1;
        end
        check32("pc", pc, m_pc);
        check32("instret", instret, m_instret);
        check1("commit_low", commit, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb, ri;
        int k;
        imem_gnt = 1'b0; halt_req = 1'b0; clear_dec();

        do_reset();
        check1("idle_req", imem_req, 1'b0);
        cyc();
        check1("cycle2_req", imem_req, 1'b1);
        check32("cycle2_addr", imem_addr, 32'h0);
        do_fetch(0);
        do_exec(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0);

        do_fetch(1);
        do_exec(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h3C, 0);
        do_fetch(0);
        do_exec(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 0);
        do_fetch(0);
        do_exec(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 0);
        do_fetch(0);
        do_exec(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10, 0);
        check32("bltu_pc", pc, 32'h44);

        do_fetch(0);
        do_exec(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h3C, 0);
        do_fetch(0);
        do_exec(0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h2, 0);
        check32("trap_vector_pc", pc, 32'h100);
        do_fetch(0);
        do_exec(0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h3, 0);
        check32("jalr_pc", pc, 32'h1004);

        do_fetch(2);
        do_exec(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h8, 3);

        // halt from FETCH, grant ignored afterwards
        while (imem_req !== 1'b1) cyc();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        imem_gnt = 1'b1;
        check1("halt_f", halted, 1'b1);
        check1("halt_f_req", imem_req, 1'b0);
        repeat (3) cyc();
        imem_gnt = 1'b0;
        check1("halt_f_stay", halted, 1'b1);
        check32("halt_f_pc", pc, m_pc);
        check32("halt_f_instret", instret, m_instret);

        // async reset in the middle of EXEC
        do_reset();
        do_fetch(0);
        do_exec(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h20, 0);
        do_fetch(0);
        is_jal = 1'b1; imm = 32'h8;
        #2 rst_n = 1'b0;
        #1;
        check32("async_pc", pc, 32'h0);
        check1("async_halted", halted, 1'b0);
        check32("async_instret", instret, 32'h0);
        check1("async_commit", commit, 1'b0);
        do_reset();

        // halt in EXEC suppresses the commit
        do_fetch(0);
        is_jal = 1'b1; imm = 32'h40; halt_req = 1'b1;
        #1;
        check1("halt_e_commit", commit, 1'b0);
        cyc();
        halt_req = 1'b0; clear_dec();
        check1("halt_e", halted, 1'b1);
        check32("halt_e_pc", pc, m_pc);
        check32("halt_e_instret", instret, m_instret);
        do_reset();

        // PC and instret wrap
        do_fetch(0);
        do_exec(0, 0, 1, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        do_fetch(0);
        check32("instret_preload", instret, 32'hFFFF_FFFF);
        do_exec(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0);
        check32("wrap_pc", pc, 32'h0);
        check32("wrap_instret", instret, 32'h0);

        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            ri = (32'($urandom) & 32'h0000_0FFC) - 32'h800;
            if ($urandom_range(0, 7) == 0) ri = ri | 32'($urandom_range(1, 3));
            do_fetch($urandom_range(0, 2));
            do_exec(k < 5, k == 5 || k == 6, k >= 7, 3'($urandom_range(0, 7)),
                    ra, rb, ri, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle program-counter controller for the RV32I core. Owns the architectural PC register and sequences fetch -> execute.
- Evaluates branch and jump conditions, then drives the 2-bit select of the next-PC 4:1 mux: 00 = pc+4, 01 = pc+imm, 10 = rs1+imm (JALR).
- Also handles misaligned-target traps, stall and halt, and keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned-target trap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; held high until granted.
- imem_addr  out  32  fetch address; always equals pc.
- imem_gnt  in  1  instruction word returned this cycle.
- is_branch  in  1  decoded conditional branch.
- is_jal  in  1  decoded JAL.
- is_jalr  in  1  decoded JALR.
- funct3  in  3  branch condition code.
- rs1_data  in  32  register source 1.
- rs2_data  in  32  register source 2.
- imm  in  32  sign-extended immediate.
- stall  in  1  hold execute; no PC update.
- halt_req  in  1  stop sequencing.
- pc  out  32  current PC.
- pc_plus_4  out  32  pc + 4, for link writeback and the mux.
- next_pc_sel  out  2  mux select.
- next_pc  out  32  selected target.
- taken  out  1  control transfer in EXEC (combinational).
- commit  out  1  one-cycle pulse per retired instruction.
- trap  out  1  one-cycle pulse on misaligned target.
- halted  out  1  in HALT state.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, pc=RESET_PC, instret=0.
  - commit, trap, halted, imem_req = 0.
  - next_pc_sel=00.
- States: IDLE, FETCH, EXEC, TRAP, HALT.
  - IDLE -> FETCH unconditionally, one cycle after reset release.
  - FETCH: imem_req=1, imem_addr=pc. On imem_gnt -> EXEC; otherwise stay.
  - EXEC: decode inputs are sampled valid this cycle.
    - stall=1: stay in EXEC; pc, instret unchanged; no commit.
    - Otherwise, if target is misaligned -> TRAP.
    - Otherwise: pc<=next_pc, instret<=instret+1, commit=1, go to FETCH.
  - TRAP: pc<=TRAP_VECTOR, trap=1 for exactly this cycle, no commit, no instret increment; -> FETCH.
  - HALT: halted=1, imem_req=0, pc frozen. Exit only by reset.
- halt_req:
  - Checked in FETCH and EXEC; has priority over every other transition.
  - In EXEC, the instruction does not commit.
  - Ignored in IDLE and TRAP; takes effect on the next FETCH.
- Select priority (combinational, EXEC only):
  - is_jalr -> 10; else is_jal -> 01; else is_branch and condition true -> 01; else 00.
  - next_pc_sel=00 outside EXEC.
  - taken = (next_pc_sel != 00).
- Branch conditions by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT signed, 101 BGE signed.
  - 110 BLTU, 111 BGEU unsigned.
  - 010/011: not taken.
- Targets (all 32-bit, wrap modulo 2^32, no overflow flag):
  - pc+4.
  - pc+imm.
  - JALR: (rs1_data+imm) with bit0 forced to 0.
- Misalignment: next_pc[1:0] != 00 after JALR bit0 clearing. Only checked when taken=1.
- Stall while imem_gnt is pending has no effect; stall is sampled in EXEC only.
- imem_gnt outside FETCH is ignored.
- instret wraps from FFFF_FFFF to 0.

Test Plan:
- Reset release with RESET_PC=0 -> imem_req=1, imem_addr=0 in cycle 2. Grant with no branch/jump -> commit pulse, pc=4, instret=1.
- pc=0x40, is_branch=1, funct3=100, rs1=0xFFFF_FFFF, rs2=1, imm=0x10 -> sel=01, pc=0x50. Same operands with funct3=110 -> sel=00, pc=0x44.
- pc=0x80, is_jalr=1, rs1=0x1001, imm=0x2 -> target 0x1002 (misaligned) -> trap pulse, pc=0x100, instret unchanged. With rs1=0x1001, imm=3 -> pc=0x1004, commit.
- stall=1 for 3 cycles in EXEC with is_jal=1, imm=8 -> pc held, no commit. Stall release -> pc+=8, single commit.
- halt_req in FETCH -> halted=1, imem_req=0, pc frozen. Then rst_n=0 asynchronously mid-EXEC -> immediate pc=RESET_PC, halted=0.
- instret preloaded via 2^32 commits (or forced) at FFFF_FFFF -> next commit -> 0. pc=0xFFFF_FFFC, no branch -> pc=0.
